// File: rtl/alu_decode_issue.sv
// rtl/alu_decode_issue.sv - RV32I OP/OP-IMM decode, register read, busy scoreboard and issue register
// Optional writeback forwarding into hazard check and operand read: ALU_DECODE_BYPASS_EN
module alu_decode_issue #(
    parameter logic [31:0] REG_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_modbit,
    output logic [31:0] out_imm,
    output logic [31:0] out_rs1,
    output logic [31:0] out_rs2,
    output logic [4:0]  out_rd_addr,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        illegal
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic        is_op_imm, is_op, is_shift_imm, legal, hazard, accept, issue;
    logic [31:0] imm, rs1_val, rs2_val, busy_eff;
    logic [31:0] busy_q, busy_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic        out_valid_q, out_valid_d, illegal_q, illegal_d, modbit_q, modbit_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;

    assign opcode       = in_instr[6:0];
    assign funct3       = in_instr[14:12];
    assign funct7       = in_instr[31:25];
    assign rs1_a        = in_instr[19:15];
    assign rs2_a        = in_instr[24:20];
    assign rd_a         = in_instr[11:7];
    assign is_op_imm    = (opcode == OPC_OP_IMM);
    assign is_op        = (opcode == OPC_OP);
    assign is_shift_imm = is_op_imm && (funct3 == 3'b001 || funct3 == 3'b101);

    always_comb begin
        legal = 1'b0;
        if (is_op_imm) begin
            case (funct3)
                3'b001:  legal = (funct7 == F7_ZERO);
                3'b101:  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                default: legal = 1'b1;
            endcase
        end else if (is_op) begin
            legal = (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
        end
    end

    always_comb begin
        imm = '0;
        if (is_shift_imm)   imm = {27'b0, in_instr[24:20]};
        else if (is_op_imm) imm = {{20{in_instr[31]}}, in_instr[31:20]};
    end

    // rf_q[0] is held at zero, so x0 reads need no special case
    always_comb begin
        rs1_val  = rf_q[rs1_a];
        rs2_val  = rf_q[rs2_a];
        busy_eff = busy_q;
`ifdef ALU_DECODE_BYPASS_EN
        if (wb_en) busy_eff[wb_addr] = 1'b0;
        if (wb_en && wb_addr != 5'd0 && wb_addr == rs1_a) rs1_val = wb_data;
        if (wb_en && wb_addr != 5'd0 && wb_addr == rs2_a) rs2_val = wb_data;
`endif
    end

    assign hazard   = busy_eff[rs1_a] | (is_op & busy_eff[rs2_a]);
    assign in_ready = rst_n & ~hazard & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign issue    = accept & legal;

    always_comb begin
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        funct3_d    = funct3_q;
        modbit_d    = modbit_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        illegal_d   = accept & ~legal;
        if (issue) begin
            out_valid_d = 1'b1;
            opcode_d    = opcode;
            funct3_d    = funct3;
            modbit_d    = (is_op || (is_op_imm && funct3 == 3'b101)) && in_instr[30];
            imm_d       = imm;
            rs1_d       = rs1_val;
            rs2_d       = is_op ? rs2_val : 32'd0;
            rd_d        = rd_a;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // clear first so a same-edge set of the same index wins
        busy_d = busy_q;
        if (wb_en) busy_d[wb_addr] = 1'b0;
        if (issue && rd_a != 5'd0) busy_d[rd_a] = 1'b1;
        busy_d[0] = 1'b0;
        rf_d = rf_q;
        if (wb_en && wb_addr != 5'd0) rf_d[wb_addr] = wb_data;
        rf_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            modbit_q    <= 1'b0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            busy_q      <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= (i == 0) ? 32'd0 : REG_INIT;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            modbit_q    <= modbit_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            rf_q        <= rf_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign illegal     = illegal_q;
    assign out_opcode  = opcode_q;
    assign out_funct3  = funct3_q;
    assign out_modbit  = modbit_q;
    assign out_imm     = imm_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_rd_addr = rd_q;
endmodule

// File: doc/alu_decode_issue.md
# alu_decode_issue

Decode-and-issue stage sitting directly upstream of the integer ALU. Accepts 32-bit RV32I OP-IMM / OP instruction words over a valid/ready handshake and decodes opcode, funct3, modbit and immediate. Reads operands from an internal 32x32 register file, tracks pending destination writes with a busy scoreboard, and presents one registered operand bundle per cycle to the ALU. The ALU result returns through a writeback port that updates the register file and clears the scoreboard.

## Interface
- REG_INIT, 32'h0000_0000, value loaded into x1..x31 on reset (x0 is always 0)
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  instruction word valid
- in_instr  in  32  instruction word
- in_ready  out  1  stage accepts in_instr this cycle
- out_valid  out  1  operand bundle valid to ALU
- out_ready  in  1  ALU consumes bundle this cycle
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_modbit  out  1  instr[30] for OP and for OP-IMM funct3=101; 0 otherwise
- out_imm  out  32  decoded immediate
- out_rs1  out  32  rs1 operand value
- out_rs2  out  32  rs2 operand value (0 for OP-IMM)
- out_rd_addr  out  5  destination register index
- wb_en  in  1  writeback strobe from ALU stage
- wb_addr  in  5  writeback register index
- wb_data  in  32  writeback data
- illegal  out  1  one-cycle pulse: rejected instruction

## Operation
- Legal: opcode 0010011 (all funct3; funct3=001 requires instr[31:25]=0000000; funct3=101 requires 0000000 or 0100000); opcode 0110011 with instr[31:25]=0000000, or 0100000 only with funct3 000/101. Anything else illegal.
- Immediate: OP-IMM shifts (funct3 001/101) -> {27'b0, instr[24:20]}; other OP-IMM -> sign-extended instr[31:20]; OP -> 0.
- Register file: x0 reads 0, writes to x0 ignored. wb_en writes wb_data at the rising edge.
- Scoreboard: 32-bit busy vector, bit 0 never set. Set busy[rd] on issue of a legal instruction with rd!=0; clear busy[wb_addr] on wb_en. Same-edge set and clear of the same index: set wins.
- Hazard: busy[rs1], or busy[rs2] for OP. Hazard holds in_ready low.
- in_ready = rst_n & ~hazard & (~out_valid | out_ready).
- Illegal word accepted with in_ready high: not issued, scoreboard untouched, illegal pulses next cycle, out_valid unchanged unless the current bundle is consumed.
- Output bundle is a single register stage; holds stable while out_valid & ~out_ready.

## Timing
- Reset: out_valid=0, illegal=0, busy=0, all out_* data=0, x1..x31=REG_INIT. Reset mid-operation discards the held bundle and all pending scoreboard bits.
- Latency: accept at edge N -> out_valid high after edge N (1 cycle).
- Back-to-back throughput 1/cycle with out_ready held high and no hazards.
- Dependent instruction after a producer: ALU result returns as wb_en at least one cycle after issue; stall duration defined under Configuration.
- Operand sampling happens at the accept edge only; later writebacks do not modify a held bundle.

## Configuration
- ALU_DECODE_BYPASS_EN defined: hazard evaluation treats a register as not busy when wb_en & wb_addr matches it in the same cycle, and the operand is taken from wb_data; dependent instruction issues on the writeback cycle.
- Not defined: no forwarding; hazard uses busy only, so dependent instruction is accepted the cycle after wb_en and reads the written register file value (one extra stall cycle).

## Test plan
- Reset, then ADDI x1,x0,-5 (0xFFB00093) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFB, out_rs1=0, out_rd_addr=1, busy[1]=1.
- SRAI x2,x1,3 (0x4030D113) with x1=0x80000000 written by wb -> out_modbit=1, out_imm=3, out_rs1=0x80000000.
- ADD x3,x1,x2 issued while busy[1]=1 -> in_ready=0; wb_en x1=7 -> with macro accepted same cycle, out_rs1=7; without macro accepted one cycle later, out_rs1=7.
- out_ready=0 for 3 cycles with in_valid=1 -> bundle held unchanged, in_ready=0; release -> next instruction follows without loss or duplication.
- Word 0x0000006F (JAL) and OP funct7 0000001 -> illegal pulses once each, no out_valid, busy unchanged.
- Write to x0 via wb_en (wb_data=0xDEAD) then ADD x4,x0,x0 -> out_rs1=out_rs2=0; assert rst_n=0 while bundle held -> out_valid=0, busy=0 next cycle.
